// File: rtl/fuzzy_input_stage.sv
// fuzzy_input_stage: samples the measured (v1) and setpoint (v2) ADC readings
// every SAMPLE_DIV clocks, block-averages 2^AVG_LOG2 samples per channel and
// presents the fuzzy controller's crisp inputs: err = avg_v1 - avg_v2 and
// derr = err - previous err, qualified by a one-cycle out_valid pulse.
// Optional feature: define FUZZY_DERR_CLAMP_EN to saturate derr to
// [-DERR_MAX, +DERR_MAX]; the stored previous error is always unclamped.

module fuzzy_input_stage #(
  parameter int SAMPLE_DIV = 1000,
  parameter int AVG_LOG2   = 3,
  parameter int DERR_MAX   = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] v1,
  input  logic [11:0] v2,
  output logic [12:0] err,
  output logic [13:0] derr,
  output logic        out_valid
);

  localparam int TICK_W = $clog2(SAMPLE_DIV);
  localparam int ACC_W  = 12 + AVG_LOG2;
  localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int NSAMP  = 1 << AVG_LOG2;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    CALC  = 2'd1,
    OUT   = 2'd2
  } state_t;

  logic [TICK_W-1:0] tick_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [ACC_W-1:0]  acc1_reg, acc2_reg;
  logic [ACC_W-1:0]  sum1_reg, sum2_reg;
  logic [ACC_W-1:0]  acc1_next, acc2_next;
  logic              capture;
  logic              last_capture;

  state_t            state_reg;
  logic              first_reg;
  logic signed [12:0] err_prev_reg;
  logic [12:0]       err_reg;
  logic [13:0]       derr_reg;
  logic              out_valid_reg;

  logic [11:0]        avg1, avg2;
  logic signed [12:0] err_n;
  logic signed [13:0] derr_full;
  logic signed [13:0] derr_n;

  // Capture strobe on the last tick of each sample period; the final capture
  // of a block is the one that completes 2^AVG_LOG2 samples.
  assign capture      = (tick_reg == TICK_W'(SAMPLE_DIV - 1));
  assign last_capture = capture && (cnt_reg == CNT_W'(NSAMP - 1));
  assign acc1_next    = acc1_reg + ACC_W'(v1);
  assign acc2_next    = acc2_reg + ACC_W'(v2);

  // Averages are floor(sum / 2^AVG_LOG2): the top 12 bits of the block sum.
  assign avg1      = sum1_reg[ACC_W-1:AVG_LOG2];
  assign avg2      = sum2_reg[ACC_W-1:AVG_LOG2];
  assign err_n     = signed'({1'b0, avg1}) - signed'({1'b0, avg2});
  assign derr_full = {err_n[12], err_n} - {err_prev_reg[12], err_prev_reg};

  // Change-of-error selection: zero for the first block, optionally saturated.
  always_comb begin
    derr_n = derr_full;
    if (first_reg) begin
      derr_n = '0;
    end
`ifdef FUZZY_DERR_CLAMP_EN
    else if (derr_full > 14'sd0 + 14'(DERR_MAX)) begin
      derr_n = 14'(DERR_MAX);
    end else if (derr_full < -(14'sd0 + 14'(DERR_MAX))) begin
      derr_n = -(14'sd0 + 14'(DERR_MAX));
    end
`endif
  end

  // Free-running tick counter, sample counter and block accumulators; never
  // stalled by the FSM so no sample is dropped between blocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_reg <= '0;
      cnt_reg  <= '0;
      acc1_reg <= '0;
      acc2_reg <= '0;
      sum1_reg <= '0;
      sum2_reg <= '0;
    end else begin
      if (capture) begin
        tick_reg <= '0;
      end else begin
        tick_reg <= tick_reg + TICK_W'(1);
      end
      if (last_capture) begin
        // Block complete: hand the sums to the FSM and restart empty so the
        // next capture seeds the new block.
        cnt_reg  <= '0;
        sum1_reg <= acc1_next;
        sum2_reg <= acc2_next;
        acc1_reg <= '0;
        acc2_reg <= '0;
      end else if (capture) begin
        cnt_reg  <= cnt_reg + CNT_W'(1);
        acc1_reg <= acc1_next;
        acc2_reg <= acc2_next;
      end
    end
  end

  // ACCUM -> CALC -> OUT sequencer; outputs are registered leaving CALC so
  // they and out_valid are presented together while in OUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ACCUM;
      first_reg     <= 1'b1;
      err_prev_reg  <= '0;
      err_reg       <= '0;
      derr_reg      <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ACCUM: begin
          out_valid_reg <= 1'b0;
          if (last_capture) begin
            state_reg <= CALC;
          end
        end
        CALC: begin
          err_reg       <= err_n;
          derr_reg      <= derr_n;
          err_prev_reg  <= err_n;
          out_valid_reg <= 1'b1;
          state_reg     <= OUT;
        end
        OUT: begin
          out_valid_reg <= 1'b0;
          first_reg     <= 1'b0;
          state_reg     <= ACCUM;
        end
        default: begin
          out_valid_reg <= 1'b0;
          state_reg     <= ACCUM;
        end
      endcase
    end
  end

  assign err       = err_reg;
  assign derr      = derr_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_fuzzy_input_stage.sv
// Testbench for fuzzy_input_stage: directed test-plan scenarios plus random
// inputs, checked every cycle against a block-average reference model.

module tb_fuzzy_input_stage;

  localparam int SD = 4;
  localparam int AL = 2;
  localparam int DM = 1023;
  localparam int N  = 1 << AL;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] v1  = '0;
  logic [11:0] v2  = '0;
  logic [12:0] err;
  logic [13:0] derr;
  logic        out_valid;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // reference model state
  int mcyc, s1, s2, ncap, pend, pe, pd, prev_e, exp_err, exp_derr;
  bit first;
  int pc_q[$];
  int pe_q[$];
  int pd_q[$];

  fuzzy_input_stage #(
    .SAMPLE_DIV(SD),
    .AVG_LOG2  (AL),
    .DERR_MAX  (DM)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .v1       (v1),
    .v2       (v2),
    .err      (err),
    .derr     (derr),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    mcyc = 0; s1 = 0; s2 = 0; ncap = 0; pend = -1;
    prev_e = 0; first = 1'b1; exp_err = 0; exp_derr = 0;
    pc_q.delete(); pe_q.delete(); pd_q.delete();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) begin
      v1 = 12'($urandom);
      v2 = 12'($urandom);
      @(posedge clk); #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_err", $signed(err), 0);
      chk("rst_derr", $signed(derr), 0);
    end
    rst = 1'b0;
    model_reset();
  endtask

  // One clock of the model followed by a check of all outputs.
  task automatic step();
    int e, d;
    if (mcyc % SD == SD - 1) begin
      s1 += int'(v1);
      s2 += int'(v2);
      ncap++;
      if (ncap == N) begin
        e = s1 / N - s2 / N;
        d = first ? 0 : e - prev_e;
`ifdef FUZZY_DERR_CLAMP_EN
        if (d > DM) d = DM;
        if (d < -DM) d = -DM;
`endif
        pend = mcyc + 2; pe = e; pd = d; prev_e = e; first = 1'b0;
        s1 = 0; s2 = 0; ncap = 0;
      end
    end
    @(posedge clk); #1;
    mcyc++;
    if (mcyc == pend) begin
      exp_err = pe;
      exp_derr = pd;
    end
    if (out_valid === 1'b1) begin
      pc_q.push_back(mcyc);
      pe_q.push_back(int'($signed(err)));
      pd_q.push_back(int'($signed(derr)));
      $display("pulse cycle=%0d err=%0d derr=%0d", mcyc, $signed(err), $signed(derr));
    end
    chk("valid", out_valid, (mcyc == pend) ? 1 : 0);
    chk("err", $signed(err), exp_err);
    chk("derr", $signed(derr), exp_derr);
  endtask

  task automatic run_block(input logic [11:0] a, input logic [11:0] b);
    v1 = a;
    v2 = b;
    repeat (SD * N) step();
  endtask

  initial begin
    // reset state
    do_reset(3);

    // steady inputs: pulses at 17 and 33, err 256, derr 0
    run_block(12'h800, 12'h700);
    run_block(12'h800, 12'h700);
    repeat (2) step();
    chk("t1_cyc0", pc_q[0], 17);
    chk("t1_err0", pe_q[0], 256);
    chk("t1_derr0", pd_q[0], 0);
    chk("t1_cyc1", pc_q[1], 33);
    chk("t1_err1", pe_q[1], 256);
    chk("t1_derr1", pd_q[1], 0);

    // measured channel steps up after the first pulse
    do_reset(1);
    run_block(12'h800, 12'h700);
    run_block(12'h900, 12'h700);
    repeat (2) step();
    chk("t2_err1", pe_q[1], 512);
    chk("t2_derr1", pd_q[1], 256);

    // truncation: v1 = 1,2,1,2 per block
    do_reset(1);
    v2 = 12'd0;
    repeat (SD * N) begin
      v1 = ((mcyc / SD) % 2 == 0) ? 12'd1 : 12'd2;
      step();
    end
    v2 = 12'd3;
    repeat (SD * N) begin
      v1 = ((mcyc / SD) % 2 == 0) ? 12'd1 : 12'd2;
      step();
    end
    repeat (2) step();
    chk("trunc_pos", pe_q[0], 1);
    chk("trunc_neg", pe_q[1], -2);
    chk("trunc_raw", {19'd0, err}, 32'h1FFE);

    // full-scale error swing for the derr clamp
    do_reset(1);
    run_block(12'h000, 12'h000);
    run_block(12'hFFF, 12'h000);
    run_block(12'h000, 12'h000);
    repeat (2) step();
    chk("clamp_err0", pe_q[0], 0);
    chk("clamp_err1", pe_q[1], 4095);
`ifdef FUZZY_DERR_CLAMP_EN
    chk("clamp_derr1", pd_q[1], 1023);
    chk("clamp_derr2", pd_q[2], -1023);
`else
    chk("clamp_derr1", pd_q[1], 4095);
    chk("clamp_derr2", pd_q[2], -4095);
`endif

    // reset while in CALC discards the pending output
    do_reset(1);
    run_block(12'h800, 12'h700);
    run_block(12'hA00, 12'h100);
    do_reset(1);
    run_block(12'h800, 12'h700);
    repeat (2) step();
    chk("rcalc_cyc", pc_q[0], SD * N + 1);
    chk("rcalc_err", pe_q[0], 256);
    chk("rcalc_derr", pd_q[0], 0);

    // long reset with toggling inputs
    do_reset(50);

    // random inputs changing every cycle
    repeat (6 * SD * N + 2) begin
      v1 = 12'($urandom);
      v2 = 12'($urandom);
      step();
    end
    chk("rand_pulses", pc_q.size(), 6);

    // random held values per block, including sign changes
    do_reset(2);
    repeat (6) run_block(12'($urandom), 12'($urandom));
    repeat (2) step();
    chk("rand_blk_pulses", pc_q.size(), 6);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
